// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - handshake bundle between ALU units, result stage and consumer
// out_parity exists only when ALU_RESULT_PARITY_EN is defined.
interface alu_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;
  logic [WIDTH-1:0] sum_y;
  logic             sum_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_err;
`ifdef ALU_RESULT_PARITY_EN
  logic             out_parity;
`endif

  modport slave (
    input  in_valid, in_op, and_y, or_y, xor_y, sum_y, sum_cout, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_neg, out_carry, out_err
`ifdef ALU_RESULT_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output in_valid, in_op, and_y, or_y, xor_y, sum_y, sum_cout, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_neg, out_carry, out_err
`ifdef ALU_RESULT_PARITY_EN
    , input out_parity
`endif
  );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result select, flag generation and result FIFO
// Optional per-entry parity output enabled by ALU_RESULT_PARITY_EN.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_stage_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PT = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] y_q     [DEPTH];
  logic             zero_q  [DEPTH];
  logic             neg_q   [DEPTH];
  logic             carry_q [DEPTH];
  logic             err_q   [DEPTH];

  logic [WIDTH-1:0] sel_y;
  logic             sel_carry;
  logic             sel_err;
  logic             push;
  logic             pop;

  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Illegal opcodes still occupy a slot, carrying a zero result and err set.
  always_comb begin
    sel_y     = '0;
    sel_carry = 1'b0;
    sel_err   = 1'b0;
    case (bus.in_op)
      3'd0: sel_y = bus.and_y;
      3'd1: sel_y = bus.or_y;
      3'd2: sel_y = bus.xor_y;
      3'd3: sel_y = ~bus.xor_y;
      3'd4, 3'd5: begin
        sel_y     = bus.sum_y;
        sel_carry = bus.sum_cout;
      end
      default: sel_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PT) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PT) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        y_q[i]     <= '0;
        zero_q[i]  <= 1'b0;
        neg_q[i]   <= 1'b0;
        carry_q[i] <= 1'b0;
        err_q[i]   <= 1'b0;
      end
    end else if (push) begin
      y_q[wr_ptr_q]     <= sel_y;
      zero_q[wr_ptr_q]  <= (sel_y == '0);
      neg_q[wr_ptr_q]   <= sel_y[WIDTH-1];
      carry_q[wr_ptr_q] <= sel_carry;
      err_q[wr_ptr_q]   <= sel_err;
    end
  end

  assign bus.out_y     = y_q[rd_ptr_q];
  assign bus.out_zero  = zero_q[rd_ptr_q];
  assign bus.out_neg   = neg_q[rd_ptr_q];
  assign bus.out_carry = carry_q[rd_ptr_q];
  assign bus.out_err   = err_q[rd_ptr_q];

`ifdef ALU_RESULT_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
    end else if (push) begin
      par_q[wr_ptr_q] <= ^sel_y;
    end
  end

  assign bus.out_parity = par_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
// Table vectors, directed corner sequences and a randomized run against a queue model.
module tb_alu_result_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        err;
  } entry_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a_y;
    logic [31:0] o_y;
    logic [31:0] x_y;
    logic [31:0] s_y;
    logic        cout;
    logic [31:0] e_y;
    logic        e_zero;
    logic        e_neg;
    logic        e_carry;
    logic        e_err;
  } vec_t;

  entry_t model_q[$];

  function automatic entry_t ref_entry(logic [2:0] op, logic [31:0] a, logic [31:0] o,
                                       logic [31:0] x, logic [31:0] s, logic c);
    entry_t e;
    e.err   = (op > 3'd5);
    e.y     = (op == 3'd0) ? a : (op == 3'd1) ? o : (op == 3'd2) ? x :
              (op == 3'd3) ? ~x : (op <= 3'd5) ? s : 32'd0;
    e.zero  = (e.y == 32'd0);
    e.neg   = e.y[31];
    e.carry = (op == 3'd4 || op == 3'd5) ? c : 1'b0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      automatic bit do_push = bus.in_valid && (model_q.size() < DEPTH);
      automatic bit do_pop  = bus.out_ready && (model_q.size() != 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push)
        model_q.push_back(ref_entry(bus.in_op, bus.and_y, bus.or_y, bus.xor_y,
                                    bus.sum_y, bus.sum_cout));
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(string name);
    chk({name, ".valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
    chk({name, ".ready"}, 32'(bus.in_ready), 32'(model_q.size() != DEPTH));
    if (model_q.size() != 0) begin
      chk({name, ".y"}, bus.out_y, model_q[0].y);
      chk({name, ".flags"}, {28'd0, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_err},
          {28'd0, model_q[0].zero, model_q[0].neg, model_q[0].carry, model_q[0].err});
`ifdef ALU_RESULT_PARITY_EN
      chk({name, ".parity"}, 32'(bus.out_parity), 32'(^model_q[0].y));
`endif
    end
  endtask

  task automatic chk_head(string name, logic [31:0] y, logic z, logic n, logic c, logic e);
    chk({name, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".y"}, bus.out_y, y);
    chk({name, ".flags"}, {28'd0, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_err},
        {28'd0, z, n, c, e});
`ifdef ALU_RESULT_PARITY_EN
    chk({name, ".parity"}, 32'(bus.out_parity), 32'(^y));
`endif
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [31:0] a, logic [31:0] o,
                       logic [31:0] x, logic [31:0] s, logic c, logic r);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.and_y     = a;
    bus.or_y      = o;
    bus.xor_y     = x;
    bus.sum_y     = s;
    bus.sum_cout  = c;
    bus.out_ready = r;
  endtask

  vec_t vecs[10];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{3'd0, 32'h0000_00F0, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b1,
                32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'd1, 32'h1111_1111, 32'h8000_0001, 32'h3333_3333, 32'h4444_4444, 1'b1,
                32'h8000_0001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'd2, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_0000, 32'h4444_4444, 1'b1,
                32'hFFFF_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{3'd3, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 32'h4444_4444, 1'b0,
                32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'd4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0000, 1'b1,
                32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'd5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h7FFF_FFFF, 1'b0,
                32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{3'd6, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_1234, 1'b1,
                32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{3'd0, 32'h0000_0000, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b0,
                32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{3'd5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h8000_0000, 1'b1,
                32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.valid", 32'(bus.out_valid), 32'd0);
    chk("reset.ready", 32'(bus.in_ready), 32'd1);
    chk("reset.y", bus.out_y, 32'd0);
    chk("reset.flags", {28'd0, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_err}, 32'd0);
`ifdef ALU_RESULT_PARITY_EN
    chk("reset.parity", 32'(bus.out_parity), 32'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a_y, vecs[i].o_y, vecs[i].x_y, vecs[i].s_y,
            vecs[i].cout, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk_head($sformatf("vec%0d", i), vecs[i].e_y, vecs[i].e_zero, vecs[i].e_neg,
               vecs[i].e_carry, vecs[i].e_err);
      chk($sformatf("vec%0d.ready", i), 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d.popped", i), 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;
    end

    // Fill to full with back-pressure, then drain in order.
    drive(1'b1, 3'd4, 32'h1, 32'h2, 32'h3, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd3, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'h5, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("full.ready", 32'(bus.in_ready), 32'd0);
    chk_head("full.head", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_head("full.hold", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain1.ready", 32'(bus.in_ready), 32'd1);
    chk_head("drain1.head", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain2.valid", 32'(bus.out_valid), 32'd0);

    // Steady stream: one in, one out every cycle.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 3'(k % 6), $urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'b1);
      @(negedge clk);
      chk_model($sformatf("stream%0d", k));
      chk($sformatf("stream%0d.count1", k), {30'd0, bus.out_valid, bus.in_ready}, 32'd3);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream.end", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a cycle with a full FIFO.
    drive(1'b1, 3'd1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("prerst.ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.ready", 32'(bus.in_ready), 32'd1);
    chk("midrst.y", bus.out_y, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postrst.valid", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic checked against the queue model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, 1'($urandom),
            1'($urandom_range(0, 2) != 0));
      @(negedge clk);
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the ALU bitwise and arithmetic units: 32-bit XOR, AND, OR, and the adder/subtractor.
- Selects one unit output per opcode, computes status flags and buffers each result in a small FIFO.
- Uses a valid/ready handshake towards the writeback/consumer logic.
- Decouples the purely combinational ALU datapath from consumer back-pressure.

Parameters:
- WIDTH, 32, datapath width of all operand/result buses.
- DEPTH, 2, result FIFO entries; legal values 2, 4, 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a result set for this cycle
- in_ready  output  1  stage can accept; equals (count != DEPTH)
- in_op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 ADD, 5 SUB, 6/7 illegal
- and_y  input  WIDTH  AND unit output
- or_y  input  WIDTH  OR unit output
- xor_y  input  WIDTH  XOR unit output
- sum_y  input  WIDTH  adder/subtractor output
- sum_cout  input  1  adder carry-out (borrow-inverted for SUB)
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  consumer accepts head entry
- out_y  output  WIDTH  head result
- out_zero  output  1  head result == 0
- out_neg  output  1  head result MSB
- out_carry  output  1  head carry; sum_cout for ops 4/5, else 0
- out_err  output  1  head opcode was illegal (6/7)

Behaviour:
- Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same rising edge.
- Result select:
  - op0 and_y, op1 or_y, op2 xor_y, op3 ~xor_y, op4/op5 sum_y.
  - op6/op7: result = 0, err = 1, zero = 1.
  - Illegal ops are still pushed (not dropped).
- Flags are computed at push time from the selected result and stored with it in the entry: y, zero, neg, carry, err.
- Storage: circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping DEPTH-1 -> 0, and count of log2(DEPTH)+1 bits.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N when the FIFO was empty.
- Outputs come directly from storage at rd_ptr. No combinational in->out path.
- in_ready depends only on count (no combinational path from out_ready).
- Full (count==DEPTH): in_ready=0; a pop that cycle frees a slot and in_ready rises next cycle.
- Empty (count==0): out_valid=0; out_y/flags hold the stale entry and are don't-care.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Head stability: while out_valid=1 and out_ready=0, out_y and all flags stay constant.
- Reset (async assert, sync deassert handled at top level):
  - count=0, rd_ptr=0, wr_ptr=0.
  - out_valid=0, in_ready=1.
  - Storage cleared to 0, so out_y=0, out_zero=0, out_neg=0, out_carry=0, out_err=0.
- Reset mid-operation discards all buffered entries immediately.
- in_op and data inputs are ignored when push=0.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- Defined:
  - Extra output out_parity (1 bit) = XOR-reduction of the head result, stored per entry at push.
  - Reset value 0.
  - Illegal ops store parity 0.
- Undefined: port and storage bit absent; all other behaviour identical.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_y=0, all flags 0.
- Push op2, xor_y=32'hFFFF0000, out_ready=1 -> next cycle out_valid=1, out_y=FFFF0000, out_neg=1, out_zero=0, then popped; with PARITY_EN out_parity=0.
- Push op4 sum_y=0, sum_cout=1; then op3 xor_y=32'hFFFFFFFF, with out_ready=0 -> count=2 and in_ready=0. Then, with out_ready=1:
  - Head: y=0, zero=1, carry=1.
  - Next: y=0, zero=1, carry=0.
  - in_ready returns to 1 after the first pop.
- Push op7 -> out_y=0, out_err=1, out_zero=1, out_carry=0.
- Steady stream, in_valid=1 and out_ready=1 every cycle, 10 ops cycling 0..5 -> one output per cycle in order, count stays 1, pointers wrap correctly.
- Fill to count=2, assert rst_n=0 mid-cycle -> out_valid drops immediately, in_ready=1; after release no stale entries appear.
